// File: rtl/linear_network_multicast_bp_pkg.sv
// linear_network_multicast_bp_pkg: shared flit widths and cmd-mask helper for the multicast chain
package linear_network_multicast_bp_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_NODE = 4;
  localparam int MAX_NODE = 32;
  typedef logic [MAX_NODE-1:0] cmd_mask_t;
  function automatic cmd_mask_t upper_mask(input int idx);
    return ~((cmd_mask_t'(1) << (idx + 1)) - cmd_mask_t'(1));
  endfunction
endpackage

// File: rtl/linear_network_multicast_bp_if.sv
// linear_network_multicast_bp_if: input flit handshake plus per-node delivery handshakes
interface linear_network_multicast_bp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_NODE = 4
);
  logic i_en;
  logic i_valid;
  logic o_ready;
  logic [DATA_WIDTH-1:0] i_data_bus;
  logic [NUM_NODE-1:0] i_cmd;
  logic [NUM_NODE-1:0] o_valid;
  logic [NUM_NODE-1:0] i_ready;
  logic [NUM_NODE*DATA_WIDTH-1:0] o_data_bus;
  modport master (
    output i_en, i_valid, i_data_bus, i_cmd, i_ready,
    input o_ready, o_valid, o_data_bus
  );
  modport slave (
    input i_en, i_valid, i_data_bus, i_cmd, i_ready,
    output o_ready, o_valid, o_data_bus
  );
endinterface

// File: rtl/linear_network_multicast_bp_stage.sv
// linear_multicast_stage_bp: one fork register delivering locally and forwarding independently
module linear_multicast_stage_bp
  import linear_network_multicast_bp_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_NODE = 4,
  parameter int NODE_IDX = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic in_valid,
  output logic in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [NUM_NODE-1:0] in_cmd,
  output logic loc_valid,
  input  logic loc_ready,
  output logic [DATA_WIDTH-1:0] loc_data,
  output logic fwd_valid,
  input  logic fwd_ready,
  output logic [DATA_WIDTH-1:0] fwd_data,
  output logic [NUM_NODE-1:0] fwd_cmd
);
  localparam logic [NUM_NODE-1:0] HI = NUM_NODE'(upper_mask(NODE_IDX));
  logic v, local_done, fwd_done, need_loc, need_fwd, loc_hs, fwd_hs, frees, load;
  logic [DATA_WIDTH-1:0] data;
  logic [NUM_NODE-1:0] cmd;
  assign need_loc = cmd[NODE_IDX];
  assign fwd_cmd = cmd & HI;
  assign need_fwd = |fwd_cmd;
  assign loc_valid = en & v & need_loc & ~local_done;
  assign fwd_valid = en & v & need_fwd & ~fwd_done;
  assign loc_data = data;
  assign fwd_data = data;
  assign loc_hs = loc_valid & loc_ready;
  assign fwd_hs = fwd_valid & fwd_ready;
  assign frees = en & v & (~need_loc | local_done | loc_hs) & (~need_fwd | fwd_done | fwd_hs);
  assign in_ready = en & (~v | frees);
  // an all-zero mask is accepted but never occupies the stage
  assign load = in_valid & in_ready & |in_cmd;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= 1'b0;
      local_done <= 1'b0;
      fwd_done <= 1'b0;
      data <= '0;
      cmd <= '0;
    end else if (load) begin
      v <= 1'b1;
      local_done <= 1'b0;
      fwd_done <= 1'b0;
      data <= in_data;
      cmd <= in_cmd;
    end else if (frees) begin
      v <= 1'b0;
      local_done <= 1'b0;
      fwd_done <= 1'b0;
    end else begin
      local_done <= local_done | loc_hs;
      fwd_done <= fwd_done | fwd_hs;
    end
  end
endmodule

// File: rtl/linear_network_multicast_bp.sv
// linear_network_multicast_bp: pipelined multicast chain with per-node valid/ready backpressure
module linear_network_multicast_bp
  import linear_network_multicast_bp_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_NODE = DEF_NUM_NODE
) (
  input logic clk,
  input logic rst,
  linear_network_multicast_bp_if.slave bus
);
  logic v_c [NUM_NODE+1];
  logic r_c [NUM_NODE+1];
  logic [DATA_WIDTH-1:0] d_c [NUM_NODE+1];
  logic [NUM_NODE-1:0] c_c [NUM_NODE+1];
  assign v_c[0] = bus.i_valid;
  assign d_c[0] = bus.i_data_bus;
  assign c_c[0] = bus.i_cmd;
  assign bus.o_ready = r_c[0];
  assign r_c[NUM_NODE] = 1'b0;
  for (genvar k = 0; k < NUM_NODE; k++) begin : g_stage
    linear_multicast_stage_bp #(
      .DATA_WIDTH(DATA_WIDTH),
      .NUM_NODE(NUM_NODE),
      .NODE_IDX(k)
    ) u_stage (
      .clk(clk),
      .rst(rst),
      .en(bus.i_en),
      .in_valid(v_c[k]),
      .in_ready(r_c[k]),
      .in_data(d_c[k]),
      .in_cmd(c_c[k]),
      .loc_valid(bus.o_valid[k]),
      .loc_ready(bus.i_ready[k]),
      .loc_data(bus.o_data_bus[k*DATA_WIDTH +: DATA_WIDTH]),
      .fwd_valid(v_c[k+1]),
      .fwd_ready(r_c[k+1]),
      .fwd_data(d_c[k+1]),
      .fwd_cmd(c_c[k+1])
    );
  end
endmodule

// File: tb/tb_linear_network_multicast_bp.sv
// tb_linear_network_multicast_bp: scoreboard bench for the backpressured multicast chain
module tb_linear_network_multicast_bp;
  localparam int DW = 32;
  localparam int NN = 4;
  typedef struct {
    logic [DW-1:0] data;
    int acc;
    int lat;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int last_acc = 0;
  int pushed [NN];
  int got [NN];
  bit seen [NN];
  exp_t q [NN][$];
  linear_network_multicast_bp_if #(.DATA_WIDTH(DW), .NUM_NODE(NN)) bus ();
  linear_network_multicast_bp #(.DATA_WIDTH(DW), .NUM_NODE(NN)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic int pending();
    int n = 0;
    for (int k = 0; k < NN; k++) n += q[k].size();
    return n;
  endfunction
  // monitor: data must match the queue head on every valid cycle, popping on handshake
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < NN; k++) begin
        if (bus.o_valid[k]) begin
          if (q[k].size() == 0) check($sformatf("unexpected_node%0d", k), bus.o_valid[k], 0);
          else begin
            check($sformatf("data_node%0d", k), bus.o_data_bus[k*DW +: DW], q[k][0].data);
            if (!seen[k] && q[k][0].lat >= 0)
              check($sformatf("latency_node%0d", k), cyc - q[k][0].acc, q[k][0].lat);
            seen[k] = 1'b1;
            if (bus.i_ready[k]) begin
              void'(q[k].pop_front());
              seen[k] = 1'b0;
              got[k]++;
            end
          end
        end
      end
    end
  end
  task automatic send(input logic [DW-1:0] d, input logic [NN-1:0] c, input bit chk);
    bit ok = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_data_bus = d;
    bus.i_cmd = c;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (bus.o_ready) begin
        ok = 1'b1;
        last_acc = cyc;
        for (int k = 0; k < NN; k++)
          if (c[k]) begin
            q[k].push_back(exp_t'{d, cyc, chk ? 1 + k : -1});
            pushed[k]++;
          end
      end
      @(posedge clk);
      #1;
    end
    bus.i_valid = 1'b0;
    check("send_accept", ok, 1);
  endtask
  task automatic drain();
    for (int i = 0; i < 200 && pending() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check("drain_pending", pending(), 0);
  endtask
  initial begin
    int c1;
    bus.i_en = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_data_bus = '0;
    bus.i_cmd = '0;
    bus.i_ready = 4'b1111;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_ovalid", bus.o_valid, 0);
    check("reset_odata", bus.o_data_bus, 0);
    check("reset_oready", bus.o_ready, 1);
    @(posedge clk);
    #1;
    send(32'hAAAA_AAAA, 4'b0101, 1);
    drain();
    for (int j = 0; j < 4; j++) send(32'h1000_0000 + j, 4'b1111, 1);
    drain();
    bus.i_ready = 4'b1110;
    send(32'h2000_0001, 4'b0011, 1);
    fork
      send(32'h2000_0002, 4'b0011, 0);
      begin
        repeat (3) @(posedge clk);
        #1 bus.i_ready = 4'b1111;
        c1 = cyc;
      end
    join
    check("hold_next_accept_cycle", last_acc, c1);
    drain();
    bus.i_ready = 4'b0111;
    for (int j = 0; j < 4; j++) send(32'h3000_0000 + j, 4'b1000, 0);
    fork
      send(32'h3000_0004, 4'b1000, 0);
      begin
        repeat (3) begin
          @(negedge clk);
          check("full_oready", bus.o_ready, 0);
        end
        @(posedge clk);
        #1 bus.i_ready = 4'b1111;
      end
    join
    drain();
    fork
      begin
        send(32'h5000_0001, 4'b1111, 0);
        send(32'h5000_0002, 4'b0110, 0);
        send(32'h5000_0003, 4'b1001, 0);
        send(32'h5000_0004, 4'b0100, 0);
      end
      begin
        @(posedge clk);
        #1 bus.i_en = 1'b0;
        repeat (2) begin
          @(negedge clk);
          check("en_ovalid", bus.o_valid, 0);
          check("en_oready", bus.o_ready, 0);
        end
        @(posedge clk);
        #1 bus.i_en = 1'b1;
      end
    join
    drain();
    send(32'hDEAD_0000, 4'b0000, 0);
    repeat (6) @(posedge clk);
    #1;
    send(32'h7000_0001, 4'b1111, 0);
    send(32'h7000_0002, 4'b1111, 0);
    #2 rst = 1'b1;
    #1;
    check("rst_ovalid", bus.o_valid, 0);
    check("rst_odata", bus.o_data_bus, 0);
    for (int k = 0; k < NN; k++) begin
      pushed[k] -= q[k].size();
      q[k].delete();
      seen[k] = 1'b0;
    end
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    send(32'h1234_5678, 4'b0010, 1);
    drain();
    for (int k = 0; k < NN; k++) check($sformatf("count_node%0d", k), got[k], pushed[k]);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
